// File: rtl/decode_ctrl.sv
// decode_ctrl: RV32I format/immediate decoder feeding a DEPTH-entry output queue; define DECODE_CTRL_UJ_EN to decode U/J formats
module decode_ctrl #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_imm,
    output logic [2:0]  out_fmt,
    output logic [4:0]  out_rd,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [31:0] out_pc,
    output logic        out_illegal,
    output logic [15:0] illegal_cnt
);
    localparam int aw = $clog2(DEPTH);
    localparam logic [aw:0] full_cnt = (aw + 1)'(DEPTH);

    typedef struct packed {
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] pc;
    } bundle_t;

    bundle_t       mem [DEPTH];
    bundle_t       dec;
    bundle_t       head;
    logic [aw-1:0] rd_ptr;
    logic [aw-1:0] wr_ptr;
    logic [aw:0]   count;
    logic          push;
    logic          pop;

    // in_ready also drops while rst is held so nothing is taken during reset
    assign in_ready = !rst && (count < full_cnt) && !flush;
    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready && !flush;

    // decode the offered word into the bundle stored on acceptance
    always_comb begin
        dec.fmt = 3'd7;
        dec.imm = 32'h0;
        dec.rd  = in_instr[11:7];
        dec.rs1 = in_instr[19:15];
        dec.rs2 = in_instr[24:20];
        dec.pc  = in_pc;
        case (in_instr[6:0])
            7'b0110011: dec.fmt = 3'd0;
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111: begin
                dec.fmt = 3'd1;
                dec.imm = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            7'b0100011: begin
                dec.fmt = 3'd2;
                dec.imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            7'b1100011: begin
                dec.fmt = 3'd3;
                dec.imm = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
            end
`ifdef DECODE_CTRL_UJ_EN
            7'b0110111, 7'b0010111: begin
                dec.fmt = 3'd4;
                dec.imm = {in_instr[31:12], 12'h000};
            end
            7'b1101111: begin
                dec.fmt = 3'd5;
                dec.imm = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
            end
`endif
            default: ;
        endcase
    end

    // queue pointers and occupancy; flush empties the queue and blocks push/pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + aw'(1);
            if (pop) rd_ptr <= rd_ptr + aw'(1);
            count <= count + (aw + 1)'(push) - (aw + 1)'(pop);
        end
    end

    // saturating count of accepted illegal words, untouched by flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) illegal_cnt <= 16'h0;
        else if (push && dec.fmt == 3'd7 && illegal_cnt != 16'hFFFF) illegal_cnt <= illegal_cnt + 16'd1;
    end

    // queue storage; contents are only visible through the count gate below
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= dec;
    end

    assign out_valid   = count != '0;
    assign head        = out_valid ? mem[rd_ptr] : '0;
    assign out_imm     = head.imm;
    assign out_fmt     = head.fmt;
    assign out_rd      = head.rd;
    assign out_rs1     = head.rs1;
    assign out_rs2     = head.rs2;
    assign out_pc      = head.pc;
    assign out_illegal = head.fmt == 3'd7;
endmodule

// File: tb/tb_decode_ctrl.sv
// tb_decode_ctrl: directed and random checks of decode_ctrl against a queue-based reference model
module tb_decode_ctrl;
    localparam int DEPTH = 4;
`ifdef DECODE_CTRL_UJ_EN
    localparam bit uj = 1'b1;
`else
    localparam bit uj = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_imm;
    logic [2:0]  out_fmt;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [31:0] out_pc;
    logic        out_illegal;
    logic [15:0] illegal_cnt;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t        q[$];
    int unsigned icnt = 0;
    int          total = 0;
    int          bad = 0;
    bit          quiet = 1'b0;

    decode_ctrl #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_fmt(out_fmt), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_pc(out_pc), .out_illegal(out_illegal), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] ref_fmt(logic [31:0] i);
        logic [6:0] op;
        op = i[6:0];
        if (op == 7'b0110011) return 3'd0;
        if (op inside {7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111}) return 3'd1;
        if (op == 7'b0100011) return 3'd2;
        if (op == 7'b1100011) return 3'd3;
        if (uj && op inside {7'b0110111, 7'b0010111}) return 3'd4;
        if (uj && op == 7'b1101111) return 3'd5;
        return 3'd7;
    endfunction

    function automatic logic [31:0] ref_imm(logic [31:0] i);
        int v;
        case (ref_fmt(i))
            3'd1: v = $signed(i[31:20]);
            3'd2: v = $signed({i[31:25], i[11:7]});
            3'd3: v = 2 * $signed({i[31], i[7], i[30:25], i[11:8]});
            3'd4: v = int'(i[31:12]) * 4096;
            3'd5: v = 2 * $signed({i[31], i[19:12], i[20], i[30:21]});
            default: v = 0;
        endcase
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cmp_all();
        logic        v;
        logic [31:0] i;
        logic [31:0] p;
        logic [2:0]  f;
        v = q.size() != 0;
        i = v ? q[0].instr : 32'h0;
        p = v ? q[0].pc : 32'h0;
        f = v ? ref_fmt(i) : 3'd0;
        check("in_ready", 32'(in_ready), 32'(!rst && q.size() < DEPTH && !flush));
        check("out_valid", 32'(out_valid), 32'(v));
        check("out_fmt", 32'(out_fmt), 32'(f));
        check("out_imm", out_imm, v ? ref_imm(i) : 32'h0);
        check("out_rd", 32'(out_rd), v ? 32'(i[11:7]) : 32'h0);
        check("out_rs1", 32'(out_rs1), v ? 32'(i[19:15]) : 32'h0);
        check("out_rs2", 32'(out_rs2), v ? 32'(i[24:20]) : 32'h0);
        check("out_pc", out_pc, p);
        check("out_illegal", 32'(out_illegal), 32'(v && f == 3'd7));
        check("illegal_cnt", 32'(illegal_cnt), icnt);
    endtask

    // one clock: drive at the falling edge, check, advance model at the rising edge
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic fl, input logic ordy);
        bit acc;
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc;
        flush     = fl;
        out_ready = ordy;
        #1;
        if (!quiet) cmp_all();
        acc = v && q.size() < DEPTH && !fl;
        @(posedge clk);
        if (fl) q.delete();
        else begin
            if (q.size() != 0 && ordy) void'(q.pop_front());
            if (acc) begin
                q.push_back('{ins, pc});
                if (ref_fmt(ins) == 3'd7 && icnt < 65535) icnt++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic push_chk(input string tag, input logic [31:0] ins,
                            input logic [2:0] efmt, input logic [31:0] eimm);
        cycle(1'b1, ins, 32'h200, 1'b0, 1'b0);
        #1;
        check({tag, "_fmt"}, 32'(out_fmt), 32'(efmt));
        check({tag, "_imm"}, out_imm, eimm);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    endtask

    logic [31:0] r;
    logic [6:0]  ops [13];

    initial begin
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111,
                7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0000000, 7'b1111111};
        @(negedge clk);
        #1;
        cmp_all();
        @(negedge clk);
        rst = 1'b0;

        cycle(1'b1, 32'hFFF00093, 32'h100, 1'b0, 1'b0);
        #1;
        check("addi_valid", 32'(out_valid), 32'h1);
        check("addi_fmt", 32'(out_fmt), 32'h1);
        check("addi_imm", out_imm, 32'hFFFFFFFF);
        check("addi_rd", 32'(out_rd), 32'h1);
        check("addi_rs1", 32'(out_rs1), 32'h0);
        check("addi_pc", out_pc, 32'h100);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        push_chk("beq", 32'hFE000EE3, 3'd3, 32'hFFFFFFFC);
        push_chk("lui", 32'h123452B7, uj ? 3'd4 : 3'd7, uj ? 32'h12345000 : 32'h0);
        push_chk("jal", 32'h008000EF, uj ? 3'd5 : 3'd7, uj ? 32'h00000008 : 32'h0);

        for (int k = 0; k < DEPTH; k++) cycle(1'b1, 32'h00A00113 + (k << 7), 32'h400 + 4 * k, 1'b0, 1'b0);
        #1;
        check("full_in_ready", 32'(in_ready), 32'h0);
        cycle(1'b1, 32'h00100093, 32'h500, 1'b0, 1'b0);
        for (int k = 0; k < DEPTH; k++) begin
            #1;
            check("drain_pc", out_pc, 32'h400 + 4 * k);
            cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        end
        #1;
        check("drained_valid", 32'(out_valid), 32'h0);

        cycle(1'b1, 32'h00208033, 32'h600, 1'b0, 1'b0);
        cycle(1'b1, 32'h00112023, 32'h604, 1'b0, 1'b0);
        cycle(1'b1, 32'h00000013, 32'h608, 1'b1, 1'b1);
        #1;
        check("flush_valid", 32'(out_valid), 32'h0);
        check("flush_in_ready", 32'(in_ready), 32'h1);

        for (int k = 0; k < DEPTH; k++) cycle(1'b1, 32'h0, 32'h700 + 4 * k, 1'b0, 1'b0);
        check("pre_rst_cnt", 32'(illegal_cnt != 16'h0), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_cnt", 32'(illegal_cnt), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h0);
        check("rst_imm", out_imm, 32'h0);
        q.delete();
        icnt = 0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'h1);

        for (int k = 0; k < 3; k++) cycle(1'b1, 32'h0, 32'h800 + 4 * k, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("zero_illegal", 32'(out_illegal), 32'h1);
            cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        end
        #1;
        check("illegal_cnt3", 32'(illegal_cnt), 32'h3);

        quiet = 1'b1;
        for (int k = 0; k < 65532; k++) cycle(1'b1, 32'h0, 32'h0, 1'b0, 1'b1);
        quiet = 1'b0;
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        #1;
        check("cnt_preload", 32'(illegal_cnt), 32'hFFFF);
        cycle(1'b1, 32'h0, 32'h900, 1'b0, 1'b1);
        #1;
        check("cnt_saturate", 32'(illegal_cnt), 32'hFFFF);

        rst = 1'b1;
        q.delete();
        icnt = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 600; k++) begin
            r = $urandom();
            cycle(($urandom() & 3) != 0, {r[31:7], ops[$urandom_range(12)]}, $urandom(),
                  ($urandom() & 15) == 0, ($urandom() & 1) != 0);
        end
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
